mult_seq_ctrl: RTL

//  Control sequencer for the shift-add multiplier datapath. Drives the 2-bit
//  c1/c2 op codes of the accumulator register (areg) and of the multiplier

---
 rtl/mult_pkg.sv | 42 ++++
 rtl/mult_seq_ctrl_if.sv | 24 ++
 rtl/mult_seq_ctrl_bit_counter.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: register op codes,
// FSM state encoding and the state-to-output decoder.
package mult_pkg;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] a_op;
        logic [1:0] q_op;
        logic       busy;
        logic       done;
    } ctrl_out_t;

    // Moore decode: every control output is a pure function of the state.
    function automatic ctrl_out_t decode(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            IDLE:  o = '0;
            INIT:  begin o.a_op = OP_CLEAR; o.q_op = OP_LOAD;  o.busy = 1'b1; end
            TEST:  begin o.busy = 1'b1; end
            ADD:   begin o.a_op = OP_LOAD;  o.busy = 1'b1; end
            SHIFT: begin o.a_op = OP_SHIFT; o.q_op = OP_SHIFT; o.busy = 1'b1; end
            DONE:  begin o.busy = 1'b1; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the multiplier sequencer and its areg/qreg datapath.
// Handshake: start is a request sampled only while busy=0; busy rises the cycle
// after start is taken and stays high through the single done cycle.
interface mult_seq_ctrl_if;
    logic start;
    logic abort;
    logic q0;
    logic a_c1;
    logic a_c2;
    logic q_c1;
    logic q_c2;
    logic busy;
    logic done;

    modport master (
        input  start, abort, q0,
        output a_c1, a_c2, q_c1, q_c2, busy, done
    );

    modport slave (
        output start, abort, q0,
        input  a_c1, a_c2, q_c1, q_c2, busy, done
    );
endinterface

// File: rtl/mult_seq_ctrl_bit_counter.sv
// Counts processed multiplier bits; last flags the final bit so the
// sequencer can leave SHIFT for DONE instead of looping back to TEST.
module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    // Saturates at WIDTH-1 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: steps TEST/ADD/SHIFT once per
// multiplier bit and drives the areg/qreg op codes from registered state.
module mult_seq_ctrl import mult_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_seq_ctrl_if.master        bus,
    output state_t                 dbg_state
);
    state_t    state;
    state_t    nxt;
    ctrl_out_t outs_q;
    logic      last;
    logic      cnt_clr;
    logic      cnt_inc;

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (last)
    );

    assign cnt_clr = (state == INIT);
    assign cnt_inc = (state == SHIFT) && !bus.abort;

    // TEST is a dedicated cycle because q0 only settles after the INIT/SHIFT edge.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = INIT;
            INIT:    nxt = TEST;
            TEST:    nxt = bus.q0 ? ADD : SHIFT;
            ADD:     nxt = SHIFT;
            SHIFT:   nxt = last ? DONE : TEST;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (bus.abort) nxt = IDLE;
    end

    // Outputs are registered alongside the state, so they always equal decode(state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            outs_q <= '0;
        end else begin
            state  <= nxt;
            outs_q <= decode(nxt);
        end
    end

    assign bus.a_c1 = outs_q.a_op[1];
    assign bus.a_c2 = outs_q.a_op[0];
    assign bus.q_c1 = outs_q.q_op[1];
    assign bus.q_c2 = outs_q.q_op[0];
    assign bus.busy = outs_q.busy;
    assign bus.done = outs_q.done;
    assign dbg_state = state;
endmodule
